// File: rtl/deserializer_out.sv
// deserializer_out: comma-aligned receiver for the 9-bit serial frame link,
// assembling {word3, word2, word1} into a 27-bit frame with a valid strobe.
module deserializer_out #(
   parameter int         LOCK_CNT = 2,
   parameter logic [7:0] COMMA    = 8'h3C
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_i,
   output logic [26:0] data_o,
   output logic        valid_o,
   output logic        locked_o,
   output logic        err_o
);
   typedef enum logic [1:0] {ST_HUNT, ST_IDLE, ST_DATA} state_t;
   localparam logic [3:0] LOCK = 4'(LOCK_CNT);
   state_t      state, state_nx;
   logic [8:0]  sr;
   logic [3:0]  bitcnt, bitcnt_nx, commas, commas_nx;
   logic [1:0]  widx, widx_nx;
   logic [17:0] stage, stage_nx;
   logic [26:0] data_nx;
   logic        valid_nx, err_nx, comma_hit, wb, slip;
   assign comma_hit = sr == {1'b1, COMMA};
   assign wb        = bitcnt == 4'd8;
   // an off-boundary comma while slot 0 or slot 1 is being assembled means the phase moved
   assign slip = comma_hit && !wb && (state == ST_IDLE || (state == ST_DATA && widx == 2'd1));
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= ST_HUNT;
         sr      <= '0;
         bitcnt  <= '0;
         commas  <= '0;
         widx    <= '0;
         stage   <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         state   <= state_nx;
         sr      <= {data_i, sr[8:1]};
         bitcnt  <= bitcnt_nx;
         commas  <= commas_nx;
         widx    <= widx_nx;
         stage   <= stage_nx;
         data_o  <= data_nx;
         valid_o <= valid_nx;
         err_o   <= err_nx;
      end
   end
   always_comb begin
      state_nx  = state;
      bitcnt_nx = wb ? 4'd0 : bitcnt + 4'd1;
      commas_nx = commas;
      widx_nx   = widx;
      stage_nx  = stage;
      data_nx   = data_o;
      valid_nx  = 1'b0;
      err_nx    = 1'b0;
      if (state == ST_HUNT) begin
         if (comma_hit && (commas == 4'd0 || !wb)) begin
            bitcnt_nx = 4'd0;
            commas_nx = 4'd1;
            state_nx  = (LOCK == 4'd1) ? ST_IDLE : ST_HUNT;
         end else if (wb && commas != 4'd0) begin
            commas_nx = comma_hit ? commas + 4'd1 : 4'd0;
            state_nx  = (comma_hit && commas + 4'd1 == LOCK) ? ST_IDLE : ST_HUNT;
         end
      end else if (slip) begin
         err_nx    = 1'b1;
         state_nx  = ST_HUNT;
         bitcnt_nx = 4'd0;
         commas_nx = 4'd1;
         widx_nx   = 2'd0;
      end else if (wb && state == ST_IDLE && !comma_hit) begin
         if (!sr[8]) begin
            stage_nx[8:0] = sr;
            widx_nx       = 2'd1;
            state_nx      = ST_DATA;
         end else begin
            err_nx    = 1'b1;
            state_nx  = ST_HUNT;
            commas_nx = 4'd0;
         end
      end else if (wb && state == ST_DATA) begin
         if (widx == 2'd1) begin
            stage_nx[17:9] = sr;
            widx_nx        = 2'd2;
         end else begin
            data_nx  = {sr, stage};
            valid_nx = 1'b1;
            widx_nx  = 2'd0;
            state_nx = ST_IDLE;
         end
      end
   end
   always_comb locked_o = state != ST_HUNT;
endmodule
